pingpong_buf: RTL and testbench

//  Two-bank (ping-pong) block buffer built on a 2*DEPTH-word internal data memory; next generation of data_mem.

---
 rtl/pingpong_buf.sv | 148 ++++++++++++++
 tb/tb_pingpong_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buf.sv
// Two-bank ping-pong block buffer. The producer fills one bank while the
// consumer drains the other, and the banks swap when a block completes.
// Optional feature macro: PPBUF_ERR_EN adds the sticky wr_overflow and
// rd_underflow flags. In the default build those ports and flags are absent.
module pingpong_buf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [ADDR_WIDTH:0]   rd_len
`ifdef PPBUF_ERR_EN
  ,
  output logic                  wr_overflow,
  output logic                  rd_underflow
`endif
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

  bank_st_e                st_q [2];
  bank_st_e                st_d [2];
  logic [ADDR_WIDTH:0]     len_q [2];
  logic                    wr_bank_q, rd_bank_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem [2*Depth];
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q, rd_last_q;

  logic wr_acc, rd_acc, wr_is_last, rd_is_last;

  // Handshake decode from registered state only, so there is no same-cycle bypass.
  always_comb begin
    wr_ready   = (st_q[wr_bank_q] == StEmpty) || (st_q[wr_bank_q] == StFilling);
    rd_ready   = (st_q[rd_bank_q] == StFull) || (st_q[rd_bank_q] == StDraining);
    wr_acc     = wr_en && wr_ready;
    rd_acc     = rd_en && rd_ready;
    // A block also ends automatically when the bank reaches capacity.
    wr_is_last = wr_last || (wr_ptr_q == {ADDR_WIDTH{1'b1}});
    rd_is_last = ({1'b0, rd_ptr_q} == (len_q[rd_bank_q] - {{ADDR_WIDTH{1'b0}}, 1'b1}));
    rd_len     = rd_ready ? len_q[rd_bank_q] : '0;
  end

  // Per-bank next state. The writer and the reader never own the same
  // non-empty bank, so both updates can be applied in the same cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (wr_acc && (wr_bank_q == 1'(b))) begin
        st_d[b] = wr_is_last ? StFull : StFilling;
      end
      if (rd_acc && (rd_bank_q == 1'(b))) begin
        st_d[b] = rd_is_last ? StEmpty : StDraining;
      end
    end
  end

  // Bank state, lengths, bank selects and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= StEmpty;
        len_q[b] <= '0;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b] <= st_d[b];
      end
      if (wr_acc) begin
        if (wr_is_last) begin
          len_q[wr_bank_q] <= {1'b0, wr_ptr_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
          wr_bank_q        <= ~wr_bank_q;
          wr_ptr_q         <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
      if (rd_acc) begin
        if (rd_is_last) begin
          rd_bank_q <= ~rd_bank_q;
          rd_ptr_q  <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Data storage. Reset does not clear it because stale words become unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_bank_q, wr_ptr_q}] <= wr_data;
    end
  end

  // Registered read port with one cycle of latency. rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_last_q  <= rd_acc && rd_is_last;
      if (rd_acc) begin
        rd_data_q <= mem[{rd_bank_q, rd_ptr_q}];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

`ifdef PPBUF_ERR_EN
  logic wr_ovf_q, rd_unf_q;

  // Sticky error flags. They record dropped requests and clear only on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ovf_q <= 1'b0;
      rd_unf_q <= 1'b0;
    end else begin
      if (wr_en && !wr_ready) wr_ovf_q <= 1'b1;
      if (rd_en && !rd_ready) rd_unf_q <= 1'b1;
    end
  end

  assign wr_overflow  = wr_ovf_q;
  assign rd_underflow = rd_unf_q;
`endif

endmodule

// File: tb/tb_pingpong_buf.sv
// Self-checking bench for pingpong_buf. The reference model tracks completed
// blocks as a FIFO of words plus a FIFO of block lengths.
module tb_pingpong_buf;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, wr_en, wr_last, rd_en;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_ready, rd_valid, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_len;
`ifdef PPBUF_ERR_EN
  logic          wr_overflow, rd_underflow;
`endif

  pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .rd_len   (rd_len)
`ifdef PPBUF_ERR_EN
    ,
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] wq[$];    // words of completed, not yet read blocks
  int            lq[$];    // lengths of those blocks, oldest first
  logic [DW-1:0] part[$];  // block currently being written
  int            ridx;
  logic [DW-1:0] e_data;
  logic          e_valid, e_last, e_ovf, e_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    lq.delete();
    part.delete();
    ridx    = 0;
    e_data  = '0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_ovf   = 1'b0;
    e_unf   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("wr_ready", 32'(wr_ready), 32'(lq.size() < 2));
    chk("rd_ready", 32'(rd_ready), 32'(lq.size() > 0));
    if (lq.size() > 0) chk("rd_len", 32'(rd_len), 32'(lq[0]));
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_last", 32'(rd_last), 32'(e_last));
    chk("rd_data", 32'(rd_data), 32'(e_data));
`ifdef PPBUF_ERR_EN
    chk("wr_overflow", 32'(wr_overflow), 32'(e_ovf));
    chk("rd_underflow", 32'(rd_underflow), 32'(e_unf));
`endif
  endtask

  // Check the current outputs, drive one cycle of inputs and advance the model.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic wl, input logic re);
    bit mwr, mrd;
    check_outputs();
    wr_en   = we;
    wr_data = wd;
    wr_last = wl;
    rd_en   = re;
    mwr = (lq.size() < 2);
    mrd = (lq.size() > 0);
    if (we && !mwr) e_ovf = 1'b1;
    if (re && !mrd) e_unf = 1'b1;
    e_valid = re && mrd;
    e_last  = 1'b0;
    if (re && mrd) begin
      e_data = wq.pop_front();
      e_last = (ridx == lq[0] - 1);
      if (e_last) begin
        void'(lq.pop_front());
        ridx = 0;
      end else begin
        ridx++;
      end
    end
    if (we && mwr) begin
      part.push_back(wd);
      if (wl || part.size() == DEPTH) begin
        lq.push_back(part.size());
        foreach (part[i]) wq.push_back(part[i]);
        part.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    wr_en   = 1'($urandom_range(0, 1));
    rd_en   = 1'($urandom_range(0, 1));
    wr_last = 1'b0;
    wr_data = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
  endtask

  initial begin
    int pw, pr;
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_last = 1'b0;
    wr_data = '0;
    @(negedge clk);
    do_reset();

    // Fill one bank to capacity and then read it back to back.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Short block that ends with wr_last.
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00A2, 1'b0, 1'b0);
    step(1'b1, 16'h00A3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Both banks full: the 17th write is dropped. A freed bank is writable again.
    for (int i = 0; i < 17; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0BAD, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0055, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // The last write of one bank and the last read of the other in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0200 + 16'(i), 1'(i == 3), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0300 + 16'(i), 1'(i == 3), 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Reads while both banks are empty are dropped.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of a block being read.
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0400 + 16'(i), 1'(i == 4), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic. The write and read rates change every 100 cycles.
    for (int c = 0; c < 1200; c++) begin
      if (c % 100 == 0) begin
        pw = $urandom_range(20, 100);
        pr = $urandom_range(20, 100);
      end
      step(1'($urandom_range(0, 99) < pw), 16'($urandom), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 99) < pr));
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
